// File: rtl/psum_glb_write_arbiter_if.sv
// Bus between the west psum routers and the GLB psum write arbiter.
// The master side is the set of routers, and it also drives clear.
// The slave side is the arbiter, which owns the GLB write port.
interface psum_glb_write_arbiter_if #(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10,
  parameter int X_dim             = 5,
  parameter int NUM_REQ           = 3
);
  logic                                   clear_i;
  logic [NUM_REQ-1:0]                     req_i;
  logic [NUM_REQ*DATA_BITWIDTH*X_dim-1:0] req_data_i;
  logic [NUM_REQ-1:0]                     ack_o;
  logic                                   write_en_glb_psum;
  logic [ADDR_BITWIDTH_GLB-1:0]           w_addr_glb_psum;
  logic [DATA_BITWIDTH-1:0]               w_data_glb_psum;
  logic                                   busy_o;
  logic [NUM_REQ-1:0]                     overflow_o;

  modport master (
    output clear_i, req_i, req_data_i,
    input  ack_o, write_en_glb_psum, w_addr_glb_psum, w_data_glb_psum,
           busy_o, overflow_o
  );

  modport slave (
    input  clear_i, req_i, req_data_i,
    output ack_o, write_en_glb_psum, w_addr_glb_psum, w_data_glb_psum,
           busy_o, overflow_o
  );
endinterface

// File: rtl/psum_glb_write_arbiter.sv
// Round-robin arbiter for the single GLB psum write port.
// A granted router's X_dim-word vector is captured in one cycle.
// It is then written one word per cycle into that router's own GLB region.
// The write address comes from a running per-router pointer.
module psum_glb_write_arbiter #(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10,
  parameter int X_dim             = 5,
  parameter int NUM_REQ           = 3,
  parameter int PSUM_LOAD_ADDR    = 0,
  parameter int REGION_SIZE       = 64
) (
  input logic                  clk,
  input logic                  reset,
  psum_glb_write_arbiter_if.slave bus
);
  localparam int VW = DATA_BITWIDTH * X_dim;
  localparam int PW = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1;
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int KW = (X_dim > 1) ? $clog2(X_dim) : 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                       state_q;
  logic [GW-1:0]                lastGrant_q;
  logic [GW-1:0]                grantReg_q;
  logic [KW-1:0]                wordCnt_q;
  logic [VW-1:0]                shiftBuf_q;
  logic [PW-1:0]                ptr_q [NUM_REQ];
  logic [NUM_REQ-1:0]           ack_q;
  logic [NUM_REQ-1:0]           overflow_q;
  logic                         wen_q;
  logic                         busy_q;
  logic [ADDR_BITWIDTH_GLB-1:0] addr_q;
  logic [DATA_BITWIDTH-1:0]     data_q;

  logic                         grantValid_d;
  logic [GW-1:0]                grant_d;
  logic [GW-1:0]                cand_d;
  logic [VW-1:0]                grantVec_d;
  logic [PW-1:0]                curPtr_d;
  logic [PW-1:0]                nextPtr_d;

  // Base of router g's region plus its pointer, truncated to the GLB address width.
  function automatic logic [ADDR_BITWIDTH_GLB-1:0] regionAddr(input logic [GW-1:0] g,
                                                              input logic [PW-1:0] p);
    return ADDR_BITWIDTH_GLB'(PSUM_LOAD_ADDR + int'(g) * REGION_SIZE + int'(p));
  endfunction

  // Pick the first requester after the last one served, wrapping around.
  always_comb begin
    grantValid_d = 1'b0;
    grant_d      = '0;
    cand_d       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand_d = GW'((int'(lastGrant_q) + off) % NUM_REQ);
      if (!grantValid_d && bus.req_i[cand_d]) begin
        grantValid_d = 1'b1;
        grant_d      = cand_d;
      end
    end
  end

  // Select the winner's vector, and derive the pointer step for the word being written.
  always_comb begin
    grantVec_d = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (grant_d == GW'(n)) grantVec_d = bus.req_data_i[n*VW +: VW];
    end
    curPtr_d  = ptr_q[grantReg_q];
    nextPtr_d = curPtr_d + 1'b1;
  end

  // Grant/serialise FSM with all bus outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lastGrant_q <= GW'(NUM_REQ - 1);
      grantReg_q  <= '0;
      wordCnt_q   <= '0;
      shiftBuf_q  <= '0;
      for (int n = 0; n < NUM_REQ; n++) ptr_q[n] <= '0;
      ack_q       <= '0;
      overflow_q  <= '0;
      wen_q       <= 1'b0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          if (bus.clear_i) begin
            for (int n = 0; n < NUM_REQ; n++) ptr_q[n] <= '0;
            overflow_q <= '0;
          end else if (grantValid_d) begin
            shiftBuf_q  <= grantVec_d >> DATA_BITWIDTH;
            data_q      <= grantVec_d[DATA_BITWIDTH-1:0];
            addr_q      <= regionAddr(grant_d, ptr_q[grant_d]);
            wen_q       <= 1'b1;
            busy_q      <= 1'b1;
            ack_q       <= NUM_REQ'(1) << grant_d;
            grantReg_q  <= grant_d;
            lastGrant_q <= grant_d;
            wordCnt_q   <= '0;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          ack_q              <= '0;
          ptr_q[grantReg_q]  <= nextPtr_d;
          if (curPtr_d == '1) overflow_q[grantReg_q] <= 1'b1;
          if (wordCnt_q == KW'(X_dim - 1)) begin
            state_q <= IDLE;
            wen_q   <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
          end else begin
            wordCnt_q  <= wordCnt_q + 1'b1;
            addr_q     <= regionAddr(grantReg_q, nextPtr_d);
            data_q     <= shiftBuf_q[DATA_BITWIDTH-1:0];
            shiftBuf_q <= shiftBuf_q >> DATA_BITWIDTH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack_o             = ack_q;
  assign bus.overflow_o        = overflow_q;
  assign bus.write_en_glb_psum = wen_q;
  assign bus.busy_o            = busy_q;
  assign bus.w_addr_glb_psum   = addr_q;
  assign bus.w_data_glb_psum   = data_q;
endmodule

// File: tb/tb_psum_glb_write_arbiter.sv
// Scoreboard testbench for psum_glb_write_arbiter.
// Expected GLB writes are queued when each request is set up.
// A negedge monitor pops and compares every observed write.
module tb_psum_glb_write_arbiter;
  localparam int DW   = 16;
  localparam int AW   = 10;
  localparam int XD   = 5;
  localparam int NR   = 3;
  localparam int BASE = 0;
  localparam int RS   = 64;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk;
  logic reset;
  exp_t expQ[$];
  int   mdlPtr [NR];
  int   errors;
  int   checks;
  int   ackOrder [32];
  int   ackCycle [32];
  int   ackCount;

  psum_glb_write_arbiter_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW),
                              .X_dim(XD), .NUM_REQ(NR)) bus ();

  psum_glb_write_arbiter #(
    .DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW), .X_dim(XD), .NUM_REQ(NR),
    .PSUM_LOAD_ADDR(BASE), .REGION_SIZE(RS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare each GLB write against the head of the scoreboard, and check that busy tracks the strobe.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      checks++;
      if (bus.busy_o !== bus.write_en_glb_psum) begin
        errors++;
        $display("[TB] FAIL busy_vs_wen: got busy=%b, expected %b", bus.busy_o, bus.write_en_glb_psum);
      end
      if (bus.write_en_glb_psum === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_write: got addr=%0d data=%0d, expected no write",
                   bus.w_addr_glb_psum, bus.w_data_glb_psum);
        end else begin
          e = expQ.pop_front();
          if (bus.w_addr_glb_psum !== e.addr || bus.w_data_glb_psum !== e.data) begin
            errors++;
            $display("[TB] FAIL glb_write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                     bus.w_addr_glb_psum, bus.w_data_glb_psum, e.addr, e.data);
          end
        end
      end
    end
  end

  function automatic logic [DW-1:0] seedOf(input int n, input int b);
    return DW'(n * 256 + b * 8 + 1);
  endfunction

  task automatic setSlice(input int n, input logic [DW-1:0] seed);
    for (int w = 0; w < XD; w++) bus.req_data_i[(n*XD + w)*DW +: DW] = seed + DW'(w);
  endtask

  task automatic pushBurst(input int n, input logic [DW-1:0] seed);
    exp_t e;
    for (int w = 0; w < XD; w++) begin
      e.addr = AW'(BASE + n * RS + mdlPtr[n]);
      e.data = seed + DW'(w);
      expQ.push_back(e);
      mdlPtr[n] = (mdlPtr[n] + 1) % RS;
    end
  endtask

  task automatic applyReset();
    reset          = 1'b1;
    bus.req_i      = '0;
    bus.clear_i    = 1'b0;
    bus.req_data_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    expQ.delete();
    for (int n = 0; n < NR; n++) mdlPtr[n] = 0;
  endtask

  task automatic drain();
    repeat (XD + 3) @(negedge clk);
  endtask

  // Hold the requesters in mask, refresh data after each ack, and stop after total acks.
  task automatic runBursts(input logic [NR-1:0] mask, input int total);
    int cnt [NR];
    int cyc;
    ackCount = 0;
    for (int n = 0; n < NR; n++) begin
      cnt[n] = 0;
      if (mask[n]) setSlice(n, seedOf(n, 0));
    end
    bus.req_i = mask;
    cyc = 0;
    while (ackCount < total && cyc < total * (XD + 1) + 20) begin
      @(negedge clk);
      cyc++;
      for (int n = 0; n < NR; n++) begin
        if (((bus.ack_o >> n) & NR'(1)) != '0) begin
          ackOrder[ackCount] = n;
          ackCycle[ackCount] = cyc;
          ackCount++;
          cnt[n]++;
          setSlice(n, seedOf(n, cnt[n]));
        end
      end
      if (ackCount >= total) bus.req_i = '0;
    end
    bus.req_i = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.write_en_glb_psum !== 1'b0 || bus.busy_o !== 1'b0 || bus.ack_o !== '0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got wen=%b busy=%b ack=%b, expected 0 0 000",
               bus.write_en_glb_psum, bus.busy_o, bus.ack_o);
    end
    checks++;
    if (bus.w_addr_glb_psum !== '0 || bus.w_data_glb_psum !== '0 || bus.overflow_o !== '0) begin
      errors++;
      $display("[TB] FAIL reset_bus: got addr=%0d data=%0d ovf=%b, expected 0 0 000",
               bus.w_addr_glb_psum, bus.w_data_glb_psum, bus.overflow_o);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.write_en_glb_psum !== 1'b0 || bus.ack_o !== '0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got wen=%b ack=%b, expected 0 000",
               bus.write_en_glb_psum, bus.ack_o);
    end
  endtask

  task automatic test_single();
    int ackCnt, busyCnt, firstAck;
    applyReset();
    pushBurst(0, seedOf(0, 0));
    setSlice(0, seedOf(0, 0));
    bus.req_i = 3'b001;
    ackCnt = 0; busyCnt = 0; firstAck = -1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (bus.busy_o === 1'b1) busyCnt++;
      if (bus.ack_o !== '0) begin
        ackCnt++;
        if (firstAck < 0) firstAck = cyc;
        checks++;
        if (bus.ack_o !== 3'b001) begin
          errors++;
          $display("[TB] FAIL single_ack_bit: got %b, expected 001", bus.ack_o);
        end
        bus.req_i = '0;
      end
    end
    checks++;
    if (ackCnt !== 1) begin
      errors++;
      $display("[TB] FAIL single_ack_pulses: got %0d, expected 1", ackCnt);
    end
    checks++;
    if (firstAck !== 1) begin
      errors++;
      $display("[TB] FAIL single_ack_latency: got cycle %0d, expected 1", firstAck);
    end
    checks++;
    if (busyCnt !== XD) begin
      errors++;
      $display("[TB] FAIL single_busy_cycles: got %0d, expected %0d", busyCnt, XD);
    end
    checks++;
    if (expQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL single_drain: got %0d pending, expected 0", expQ.size());
    end
  endtask

  task automatic test_all_three();
    applyReset();
    for (int n = 0; n < NR; n++) pushBurst(n, seedOf(n, 0));
    runBursts(3'b111, 3);
    drain();
    checks++;
    if (ackCount !== 3) begin
      errors++;
      $display("[TB] FAIL all3_ack_count: got %0d, expected 3", ackCount);
    end
    for (int i = 0; i < 3 && i < ackCount; i++) begin
      checks++;
      if (ackOrder[i] !== i) begin
        errors++;
        $display("[TB] FAIL all3_order[%0d]: got %0d, expected %0d", i, ackOrder[i], i);
      end
    end
    for (int i = 1; i < 3 && i < ackCount; i++) begin
      checks++;
      if (ackCycle[i] - ackCycle[i-1] !== XD + 1) begin
        errors++;
        $display("[TB] FAIL all3_spacing[%0d]: got %0d, expected %0d", i,
                 ackCycle[i] - ackCycle[i-1], XD + 1);
      end
    end
    checks++;
    if (expQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL all3_drain: got %0d pending, expected 0", expQ.size());
    end
  endtask

  task automatic test_round_robin();
    int expOrder [4];
    expOrder[0] = 0; expOrder[1] = 1; expOrder[2] = 0; expOrder[3] = 1;
    applyReset();
    pushBurst(0, seedOf(0, 0));
    pushBurst(1, seedOf(1, 0));
    pushBurst(0, seedOf(0, 1));
    pushBurst(1, seedOf(1, 1));
    runBursts(3'b011, 4);
    drain();
    checks++;
    if (ackCount !== 4) begin
      errors++;
      $display("[TB] FAIL rr_ack_count: got %0d, expected 4", ackCount);
    end
    for (int i = 0; i < 4 && i < ackCount; i++) begin
      checks++;
      if (ackOrder[i] !== expOrder[i]) begin
        errors++;
        $display("[TB] FAIL rr_order[%0d]: got %0d, expected %0d", i, ackOrder[i], expOrder[i]);
      end
    end
    for (int i = 1; i < 4 && i < ackCount; i++) begin
      checks++;
      if (ackCycle[i] - ackCycle[i-1] !== XD + 1) begin
        errors++;
        $display("[TB] FAIL rr_spacing[%0d]: got %0d, expected %0d", i,
                 ackCycle[i] - ackCycle[i-1], XD + 1);
      end
    end
    checks++;
    if (expQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL rr_drain: got %0d pending, expected 0", expQ.size());
    end
  endtask

  task automatic test_wrap();
    int cyc;
    applyReset();
    for (int b = 0; b < 12; b++) pushBurst(0, seedOf(0, b));
    runBursts(3'b001, 12);
    drain();
    checks++;
    if (ackCount !== 12 || bus.overflow_o !== 3'b000) begin
      errors++;
      $display("[TB] FAIL wrap_pre: got acks=%0d ovf=%b, expected 12 000", ackCount, bus.overflow_o);
    end
    setSlice(0, seedOf(0, 12));
    pushBurst(0, seedOf(0, 12));
    bus.req_i = 3'b001;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.ack_o[0] !== 1'b1 && cyc < 20);
    bus.req_i = '0;
    checks++;
    if (cyc >= 20) begin
      errors++;
      $display("[TB] FAIL wrap_ack: got timeout, expected ack");
    end
    for (int w = 0; w < XD; w++) begin
      if (w > 0) @(negedge clk);
      checks++;
      if (bus.overflow_o !== ((w == XD - 1) ? 3'b001 : 3'b000)) begin
        errors++;
        $display("[TB] FAIL wrap_ovf_word%0d: got %b, expected %b", w, bus.overflow_o,
                 (w == XD - 1) ? 3'b001 : 3'b000);
      end
    end
    drain();
    checks++;
    if (bus.overflow_o !== 3'b001) begin
      errors++;
      $display("[TB] FAIL wrap_ovf_sticky: got %b, expected 001", bus.overflow_o);
    end
    bus.clear_i = 1'b1;
    @(negedge clk);
    bus.clear_i = 1'b0;
    for (int n = 0; n < NR; n++) mdlPtr[n] = 0;
    checks++;
    if (bus.overflow_o !== 3'b000) begin
      errors++;
      $display("[TB] FAIL wrap_clear_ovf: got %b, expected 000", bus.overflow_o);
    end
    pushBurst(0, seedOf(0, 0));
    runBursts(3'b001, 1);
    drain();
    checks++;
    if (ackCount !== 1 || expQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL wrap_after_clear: got acks=%0d pending=%0d, expected 1 0",
               ackCount, expQ.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    int cyc;
    exp_t e;
    applyReset();
    setSlice(1, seedOf(1, 5));
    for (int w = 0; w < 2; w++) begin
      e.addr = AW'(BASE + RS + w);
      e.data = seedOf(1, 5) + DW'(w);
      expQ.push_back(e);
    end
    bus.req_i = 3'b010;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.ack_o[1] !== 1'b1 && cyc < 20);
    bus.req_i = '0;
    checks++;
    if (cyc >= 20) begin
      errors++;
      $display("[TB] FAIL midrst_ack: got timeout, expected ack");
    end
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.write_en_glb_psum !== 1'b0 || bus.busy_o !== 1'b0 || bus.ack_o !== '0 ||
        bus.w_addr_glb_psum !== '0 || bus.w_data_glb_psum !== '0) begin
      errors++;
      $display("[TB] FAIL midrst_outputs: got wen=%b busy=%b ack=%b addr=%0d data=%0d, expected all 0",
               bus.write_en_glb_psum, bus.busy_o, bus.ack_o, bus.w_addr_glb_psum, bus.w_data_glb_psum);
    end
    checks++;
    if (expQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL midrst_words_before: got %0d pending, expected 0", expQ.size());
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < NR; n++) mdlPtr[n] = 0;
    pushBurst(1, seedOf(1, 0));
    runBursts(3'b010, 1);
    drain();
    checks++;
    if (ackCount !== 1 || expQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL midrst_after: got acks=%0d pending=%0d, expected 1 0", ackCount, expQ.size());
    end
  endtask

  task automatic test_clear_with_req();
    int cyc;
    applyReset();
    pushBurst(2, seedOf(2, 0));
    runBursts(3'b100, 1);
    drain();
    checks++;
    if (ackCount !== 1 || expQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL clr_setup: got acks=%0d pending=%0d, expected 1 0", ackCount, expQ.size());
    end
    setSlice(2, seedOf(2, 7));
    bus.clear_i = 1'b1;
    bus.req_i   = 3'b100;
    @(negedge clk);
    checks++;
    if (bus.ack_o !== '0 || bus.write_en_glb_psum !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_no_grant: got ack=%b wen=%b, expected 000 0",
               bus.ack_o, bus.write_en_glb_psum);
    end
    bus.clear_i = 1'b0;
    mdlPtr[2] = 0;
    pushBurst(2, seedOf(2, 7));
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.ack_o === '0 && cyc < 20);
    bus.req_i = '0;
    checks++;
    if (cyc !== 1 || bus.ack_o !== 3'b100) begin
      errors++;
      $display("[TB] FAIL clr_next_grant: got cycle=%0d ack=%b, expected 1 100", cyc, bus.ack_o);
    end
    drain();
    checks++;
    if (expQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL clr_drain: got %0d pending, expected 0", expQ.size());
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    errors         = 0;
    checks         = 0;
    ackCount       = 0;
    reset          = 1'b1;
    bus.req_i      = '0;
    bus.clear_i    = 1'b0;
    bus.req_data_i = '0;
    for (int n = 0; n < NR; n++) mdlPtr[n] = 0;
    test_reset();
    test_single();
    test_all_three();
    test_round_robin();
    test_wrap();
    test_reset_mid_burst();
    test_clear_with_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
